clk_divider: RTL and testbench

CLK_DIVIDER -- requirements
Module: clk_divider

---
 rtl/clk_divider_pkg.sv | 16 +
 rtl/clk_divider_counter.sv | 28 ++
 rtl/clk_divider.sv | 73 +++++++
 tb/tb_clk_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_divider_pkg.sv
// rtl/clk_divider_pkg.sv - shared phase type and output gate helper for the clock divider
package clk_divider_pkg;

  typedef enum logic {
    PHASE_LOW  = 1'b0,
    PHASE_HIGH = 1'b1
  } phase_e;

  // Continuous mode ignores the burst budget; burst mode needs pulses left.
  function automatic logic burst_gate(input logic out_enable,
                                      input logic option,
                                      input logic remaining_nz);
    return out_enable && (!option || remaining_nz);
  endfunction

endpackage

// File: rtl/clk_divider_counter.sv
// rtl/clk_divider_counter.sv - division counter producing one toggle event per half-period
module clk_divider_counter #(
  parameter int COUNTER_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COUNTER_BITS-1:0] divider,
  output logic                    toggle
);

  localparam logic [COUNTER_BITS-1:0] ONE = COUNTER_BITS'(1);

  logic [COUNTER_BITS-1:0] cnt;

  // >= rather than == so a divider lowered below cnt wraps on the next cycle.
  assign toggle = (cnt >= divider);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (toggle) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - glitch-free divided clock with optional counted-pulse burst mode
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int COUNTER_BITS       = 32,
  parameter int PULSE_CONTROL_BITS = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          option,
  input  logic                          write_pulse,
  input  logic                          out_enable,
  input  logic [COUNTER_BITS-1:0]       divider,
  input  logic [PULSE_CONTROL_BITS-1:0] pulse,
  output logic                          clk_o
);

  localparam logic [PULSE_CONTROL_BITS-1:0] ONE = PULSE_CONTROL_BITS'(1);

  logic                          toggle;
  logic                          gate;
  phase_e                        phase_q, phase_d;
  logic                          clk_q, clk_d;
  logic [PULSE_CONTROL_BITS-1:0] remaining_q, remaining_d;

  clk_divider_counter #(
    .COUNTER_BITS(COUNTER_BITS)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .divider(divider),
    .toggle (toggle)
  );

  assign gate  = burst_gate(out_enable, option, remaining_q != '0);
  assign clk_o = clk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= PHASE_LOW;
      clk_q       <= 1'b0;
      remaining_q <= '0;
    end else begin
      phase_q     <= phase_d;
      clk_q       <= clk_d;
      remaining_q <= remaining_d;
    end
  end

  // The enable decision is taken only at a rising toggle, so a high phase
  // always runs to its full width even if gating changes mid-pulse.
  always_comb begin
    phase_d     = phase_q;
    clk_d       = clk_q;
    remaining_d = remaining_q;
    if (toggle) begin
      if (phase_q == PHASE_LOW) begin
        phase_d = PHASE_HIGH;
        clk_d   = gate;
        if (option && gate) begin
          remaining_d = remaining_q - ONE;
        end
      end else begin
        phase_d = PHASE_LOW;
        clk_d   = 1'b0;
      end
    end
    if (write_pulse) begin
      remaining_d = pulse;
    end
  end

endmodule

// File: tb/tb_clk_divider.sv
// tb/tb_clk_divider.sv - randomized self-checking bench for clk_divider against a behavioural model
module tb_clk_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        option = 1'b0;
  logic        write_pulse = 1'b0;
  logic        out_enable = 1'b1;
  logic [31:0] divider = 32'd0;
  logic [31:0] pulse = 32'd0;
  logic        clk_o;

  int errors = 0;
  int checks = 0;

  clk_divider dut (
    .clk        (clk),
    .reset      (reset),
    .option     (option),
    .write_pulse(write_pulse),
    .out_enable (out_enable),
    .divider    (divider),
    .pulse      (pulse),
    .clk_o      (clk_o)
  );

  always #5 clk = ~clk;

  // Reference: a half-period ends once more than `divider` edges have passed
  // since the previous toggle (or reset); high phases are granted only at
  // their start, and burst mode spends one unit of budget per granted pulse.
  int          edge_n = 0;
  int          last_evt = 0;
  bit          m_high_phase = 0;
  bit          m_clk = 0;
  logic [31:0] m_rem = 0;

  always @(posedge clk) begin
    bit g;
    edge_n++;
    if (reset) begin
      m_high_phase = 0;
      m_clk        = 0;
      m_rem        = 0;
      last_evt     = edge_n;
    end else begin
      if (longint'(edge_n - last_evt - 1) >= longint'(divider)) begin
        last_evt = edge_n;
        if (!m_high_phase) begin
          g = out_enable && (!option || m_rem != 0);
          m_clk = g;
          if (option && g) m_rem = m_rem - 1;
        end else begin
          m_clk = 0;
        end
        m_high_phase = !m_high_phase;
      end
      if (write_pulse) m_rem = pulse;
    end
  end

  int rises = 0;
  bit prev_o = 0;

  always @(negedge clk) begin
    checks++;
    if (clk_o !== m_clk) begin
      errors++;
      $display("FAIL model_cmp t=%0t clk_o=%b expected=%b", $time, clk_o, m_clk);
    end
    if (clk_o === 1'b1 && !prev_o) rises++;
    prev_o = (clk_o === 1'b1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic wait_rises(input string name, input int target, input int budget);
    int n = 0;
    while (rises < target && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (rises < target) begin
      errors++;
      $display("FAIL %s timeout rises=%0d expected=%0d", name, rises, target);
    end
  endtask

  task automatic write_burst(input int count);
    write_pulse = 1'b1;
    pulse = count;
    step(1);
    write_pulse = 1'b0;
  endtask

  initial begin
    int base;
    step(3);
    check("reset_low", int'(clk_o), 0);

    // divider=0 continuous: high/low alternating from the first edge
    reset = 1'b0;
    step(1);
    check("div0_first", int'(clk_o), 1);
    step(1);
    check("div0_second", int'(clk_o), 0);
    step(1);
    check("div0_third", int'(clk_o), 1);

    // divider=3 then lowered to 1 mid-run
    divider = 3;
    step(2);
    base = rises;
    step(40);
    check("div3_rises", rises - base, 5);
    divider = 1;
    step(20);

    // gated for 15 cycles: no new pulse may start
    out_enable = 1'b0;
    base = rises;
    step(15);
    check("gated_rises", rises - base, 0);
    out_enable = 1'b1;
    base = rises;
    step(16);
    check("reenable_rises", rises - base, 4);

    // burst of 8, nothing before the write
    reset = 1'b1;
    option = 1'b1;
    divider = 0;
    step(2);
    reset = 1'b0;
    base = rises;
    step(10);
    check("burst_idle", rises - base, 0);
    write_burst(8);
    step(40);
    check("burst8", rises - base, 8);

    // gate after 3 pulses, then 5 more
    base = rises;
    write_burst(8);
    wait_rises("burst_gate_wait", base + 3, 40);
    out_enable = 1'b0;
    step(10);
    check("burst_gated", rises - base, 3);
    out_enable = 1'b1;
    step(40);
    check("burst_resume", rises - base, 8);

    // pulse=0 reload stops the burst
    base = rises;
    write_burst(8);
    wait_rises("reload_wait", base + 2, 40);
    write_burst(0);
    step(30);
    check("reload_zero", rises - base, 2);

    // reset mid-burst aborts it
    base = rises;
    write_burst(8);
    wait_rises("rst_wait", base + 2, 40);
    reset = 1'b1;
    step(1);
    check("rst_mid_low", int'(clk_o), 0);
    step(1);
    reset = 1'b0;
    step(30);
    check("rst_no_pulses", rises - base, 2);

    // randomized mix
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) option = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) out_enable = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 19) == 0) divider = $urandom_range(0, 5);
      write_pulse = ($urandom_range(0, 24) == 0);
      pulse = $urandom_range(0, 6);
      reset = ($urandom_range(0, 99) == 0);
      step(1);
    end
    write_pulse = 1'b0;
    reset = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
